// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state codes and memType encodings for the memory port arbiter
package mem_arb_pkg;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] DATA   = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;
   localparam logic [2:0] MT_B  = 3'b000;
   localparam logic [2:0] MT_H  = 3'b001;
   localparam logic [2:0] MT_W  = 3'b010;
   localparam logic [2:0] MT_BU = 3'b100;
   localparam logic [2:0] MT_HU = 3'b101;
   localparam logic [2:0] FETCH_TYPE = MT_W;
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: counts wait cycles of an in-flight access and flags the last allowed one
module arb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt;
   // expire fires in the cycle whose increment would reach the limit, so mem_req lasts TIMEOUT_CYCLES cycles
   assign expire = en & (cnt == W'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !expire) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with starvation bound, timeout and halt drain
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_type,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   input  logic              halt,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_type,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              timeout_err,
   output logic              halted
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [1:0] state;
   logic [SW-1:0] starve_cnt;
   logic fetch_ok, take_d, idle_ok, busy, expire, done;
   assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);
   assign fetch_ok = if_req & ~halt;
   assign take_d = d_req & ~(fetch_ok & (starve_cnt == SW'(STARVE_MAX)));
   // no grant while a completion pulse is out: both requests are stale or about to be re-evaluated
   assign idle_ok = (state == IDLE) & ~if_valid & ~d_valid;
   assign busy = (state == FETCH) | (state == DATA);
   assign done = busy & (mem_ack | expire);
   arb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(busy & ~mem_ack), .expire(expire)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         starve_cnt <= '0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_type <= '0;
         if_valid <= 1'b0;
         d_valid <= 1'b0;
         if_rdata <= '0;
         d_rdata <= '0;
         timeout_err <= 1'b0;
         halted <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid <= 1'b0;
         timeout_err <= 1'b0;
         if (idle_ok && take_d) begin
            state <= DATA;
            mem_req <= 1'b1;
            mem_we <= d_we;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            mem_type <= d_type;
            starve_cnt <= fetch_ok ? starve_cnt + 1'b1 : '0;
         end else if (idle_ok && fetch_ok) begin
            state <= FETCH;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            mem_wdata <= '0;
            mem_type <= FETCH_TYPE;
            starve_cnt <= '0;
         end else if (idle_ok && halt && !d_req) begin
            state <= HALTED;
            halted <= 1'b1;
         end else if (done) begin
            state <= IDLE;
            mem_req <= 1'b0;
            timeout_err <= ~mem_ack;
            if (state == FETCH) begin
               if_valid <= 1'b1;
               if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
               d_valid <= 1'b1;
               d_rdata <= mem_ack ? mem_rdata : '0;
            end
         end
      end
   end
endmodule
